// File: rtl/dmem_lsu.sv
// Load/store initiator between the RV32I execute stage and the big-endian word-wide dmem.
// Byte/half stores become a read-modify-write because dmem only writes whole words.
module dmem_lsu #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_r_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  lat_cnt_reg;

  logic misaligned;
  logic illegal;
  logic req_err;

  assign req_ready = (state_reg == IDLE);

  always_comb begin
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (req_we)
      illegal = (req_funct3 > 3'b010);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    req_err = misaligned | illegal;
  end

  // Big-endian: byte offset 0 is the most significant lane.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'b0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'b0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3,
                                              input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    if (f3 == 3'b000) begin
      case (off)
        2'd0:    res[31:24] = wdata[7:0];
        2'd1:    res[23:16] = wdata[7:0];
        2'd2:    res[15:8]  = wdata[7:0];
        default: res[7:0]   = wdata[7:0];
      endcase
    end else begin
      if (off[1]) res[15:0]  = wdata[15:0];
      else        res[31:16] = wdata[15:0];
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      funct3_reg  <= 3'b0;
      off_reg     <= 2'b0;
      wdata_reg   <= 32'b0;
      lat_cnt_reg <= 3'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'b0;
      rsp_err     <= 1'b0;
      mem_r_w     <= 1'b0;
      mem_addr    <= 32'b0;
      mem_data    <= 32'b0;
    end else begin
      rsp_valid <= 1'b0;
      mem_r_w   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            funct3_reg  <= req_funct3;
            off_reg     <= req_addr[1:0];
            wdata_reg   <= req_wdata;
            lat_cnt_reg <= 3'b0;
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'b0;
              state_reg <= RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_we && (req_funct3 == 3'b010)) begin
                mem_r_w   <= 1'b1;
                mem_data  <= req_wdata;
                state_reg <= WR;
              end else if (req_we) begin
                state_reg <= RMW_RD;
              end else begin
                state_reg <= RD;
              end
            end
          end
        end
        // Address went out in cycle 1; read word is valid MEM_LAT cycles later.
        RD: begin
          if (lat_cnt_reg == 3'(MEM_LAT)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_extend(mem_out, off_reg, funct3_reg);
            state_reg <= RESP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 3'd1;
          end
        end
        WR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'b0;
          state_reg <= RESP;
        end
        RMW_RD: begin
          if (lat_cnt_reg == 3'(MEM_LAT)) begin
            mem_r_w   <= 1'b1;
            mem_data  <= store_merge(mem_out, off_reg, funct3_reg, wdata_reg);
            state_reg <= RMW_WR;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 3'd1;
          end
        end
        RMW_WR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'b0;
          state_reg <= RESP;
        end
        default: begin
          rsp_rdata <= 32'b0;
          rsp_err   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: instance 0 runs with MEM_LAT=1, instance 1 with MEM_LAT=3,
// each against a small word memory whose read data only becomes valid after MEM_LAT cycles.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];
  logic        mem_r_w [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_data [2];
  logic [31:0] mem_out [2];

  logic [31:0] mem [2][16];
  logic [31:0] pipe [2][4];
  logic        pl_en = 1'b0;
  int          pl_idx = 0;
  logic [3:0]  pl_word = 4'd0;
  logic [31:0] pl_data = 32'd0;

  int errors = 0;
  int checks = 0;

  int          rsp_cyc, rsp_cnt, wr_cyc, wr_cnt;
  logic [31:0] cap_rdata, cap_wdata, cap_addr;
  logic        cap_err;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    dmem_lsu #(.MEM_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_we(req_we[gi]),
      .req_funct3(req_funct3[gi]), .req_addr(req_addr[gi]), .req_wdata(req_wdata[gi]),
      .rsp_valid(rsp_valid[gi]), .rsp_rdata(rsp_rdata[gi]), .rsp_err(rsp_err[gi]),
      .mem_r_w(mem_r_w[gi]), .mem_addr(mem_addr[gi]), .mem_data(mem_data[gi]),
      .mem_out(mem_out[gi])
    );
    assign mem_out[gi] = pipe[gi][LAT-1];
  end

  // Memory model: reads pushed while the LSU is idle are poisoned so early sampling shows up.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pl_en && pl_idx == i) mem[i][pl_word] <= pl_data;
      else if (mem_r_w[i]) mem[i][mem_addr[i][5:2]] <= mem_data[i];
      pipe[i][0] <= req_ready[i] ? 32'hA5A5A5A5 : mem[i][mem_addr[i][5:2]];
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end

  task automatic preload(input int idx, input logic [3:0] word, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_word = word; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request and record what happens over the following 12 cycles.
  task automatic run_req(input int idx, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we[idx] = we; req_funct3[idx] = f3; req_addr[idx] = addr; req_wdata[idx] = wdata;
    req_valid[idx] = 1'b1;
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    rsp_cyc = -1; rsp_cnt = 0; wr_cyc = -1; wr_cnt = 0;
    cap_rdata = 32'hx; cap_wdata = 32'hx; cap_addr = 32'hx; cap_err = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) cap_addr = mem_addr[idx];
      if (rsp_valid[idx]) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc = c; cap_rdata = rsp_rdata[idx]; cap_err = rsp_err[idx];
        end
      end
      if (mem_r_w[idx]) begin
        wr_cnt++;
        if (wr_cyc < 0) begin
          wr_cyc = c; cap_wdata = mem_data[idx];
        end
      end
    end
    $display("txn inst=%0d we=%0b f3=%03b addr=%08h wdata=%08h -> rsp_cyc=%0d rdata=%08h err=%0b wr_cyc=%0d wdata=%08h",
             idx, we, f3, addr, wdata, rsp_cyc, cap_rdata, cap_err, wr_cyc, cap_wdata);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'b0;
      req_addr[i] = 32'b0; req_wdata[i] = 32'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0 || rsp_rdata[i] !== 32'b0 ||
          rsp_err[i] !== 1'b0 || mem_r_w[i] !== 1'b0 || mem_addr[i] !== 32'b0 ||
          mem_data[i] !== 32'b0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got ready=%b rv=%b rd=%h err=%b rw=%b ma=%h md=%h want 1 0 0 0 0 0 0",
                 i, req_ready[i], rsp_valid[i], rsp_rdata[i], rsp_err[i], mem_r_w[i],
                 mem_addr[i], mem_data[i]);
      end
    end
    reset_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_sw;
    preload(0, 4'd4, 32'h0);
    run_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++;
    if (wr_cyc !== 1 || wr_cnt !== 1) begin
      errors++; $display("FAIL sw_write_timing got cyc=%0d cnt=%0d want 1 1", wr_cyc, wr_cnt);
    end
    checks++;
    if (cap_wdata !== 32'hDEADBEEF || cap_addr !== 32'h10) begin
      errors++; $display("FAIL sw_write_word got data=%h addr=%h want deadbeef 00000010", cap_wdata, cap_addr);
    end
    checks++;
    if (rsp_cyc !== 2 || cap_err !== 1'b0 || cap_rdata !== 32'b0 || rsp_cnt !== 1) begin
      errors++; $display("FAIL sw_rsp got cyc=%0d err=%b rdata=%h cnt=%0d want 2 0 0 1", rsp_cyc, cap_err, cap_rdata, rsp_cnt);
    end
    checks++;
    if (mem[0][4] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_mem got %h want deadbeef", mem[0][4]);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3   [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
    logic [31:0] addr [4] = '{32'h11, 32'h11, 32'h12, 32'h10};
    logic [31:0] exp  [4] = '{32'hFFFFFFF4, 32'h000000F4, 32'h00005678, 32'h12F45678};
    preload(0, 4'd4, 32'h12F45678);
    for (int t = 0; t < 4; t++) begin
      run_req(0, 1'b0, f3[t], addr[t], 32'h0);
      checks++;
      if (rsp_cyc !== 3 || cap_rdata !== exp[t] || cap_err !== 1'b0) begin
        errors++; $display("FAIL load_%0d got cyc=%0d rdata=%h err=%b want 3 %h 0", t, rsp_cyc, cap_rdata, cap_err, exp[t]);
      end
      checks++;
      if (wr_cnt !== 0 || cap_addr !== 32'h10 || rsp_cnt !== 1) begin
        errors++; $display("FAIL load_%0d_bus got wr=%0d addr=%h rsps=%0d want 0 00000010 1", t, wr_cnt, cap_addr, rsp_cnt);
      end
    end
  endtask

  task automatic test_rmw;
    logic [2:0]  f3   [3] = '{3'b000, 3'b001, 3'b000};
    logic [31:0] addr [3] = '{32'h13, 32'h12, 32'h10};
    logic [31:0] wd   [3] = '{32'hFFFFFFAB, 32'h1234CAFE, 32'h0000005A};
    logic [31:0] exp  [3] = '{32'h112233AB, 32'h1122CAFE, 32'h5A223344};
    for (int t = 0; t < 3; t++) begin
      preload(0, 4'd4, 32'h11223344);
      run_req(0, 1'b1, f3[t], addr[t], wd[t]);
      checks++;
      if (wr_cyc !== 3 || wr_cnt !== 1 || cap_wdata !== exp[t]) begin
        errors++; $display("FAIL rmw_%0d_write got cyc=%0d cnt=%0d data=%h want 3 1 %h", t, wr_cyc, wr_cnt, cap_wdata, exp[t]);
      end
      checks++;
      if (rsp_cyc !== 4 || cap_err !== 1'b0 || mem[0][4] !== exp[t]) begin
        errors++; $display("FAIL rmw_%0d_rsp got cyc=%0d err=%b mem=%h want 4 0 %h", t, rsp_cyc, cap_err, mem[0][4], exp[t]);
      end
    end
  endtask

  task automatic test_errors;
    logic        we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3   [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] addr [4] = '{32'h6, 32'h1, 32'h10, 32'h10};
    for (int t = 0; t < 4; t++) begin
      run_req(0, we[t], f3[t], addr[t], 32'hFFFFFFFF);
      checks++;
      if (rsp_cyc !== 1 || cap_err !== 1'b1 || cap_rdata !== 32'b0 || wr_cnt !== 0 || rsp_cnt !== 1) begin
        errors++; $display("FAIL err_%0d got cyc=%0d err=%b rdata=%h wr=%0d rsps=%0d want 1 1 0 0 1",
                           t, rsp_cyc, cap_err, cap_rdata, wr_cnt, rsp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    int late_rsp = 0;
    preload(0, 4'd4, 32'h11223344);
    @(negedge clk);
    req_we[0] = 1'b1; req_funct3[0] = 3'b000; req_addr[0] = 32'h13; req_wdata[0] = 32'hAB;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_r_w[0]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_mid_write_seen got none want mem_r_w within 10 cycles");
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_r_w[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 ||
        mem_addr[0] !== 32'b0 || mem_data[0] !== 32'b0) begin
      errors++; $display("FAIL rst_mid_async got rw=%b rv=%b ready=%b ma=%h md=%h want 0 0 1 0 0",
                         mem_r_w[0], rsp_valid[0], req_ready[0], mem_addr[0], mem_data[0]);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid[0] || mem_r_w[0]) late_rsp++;
    end
    checks++;
    if (late_rsp !== 0 || mem[0][4] !== 32'h11223344 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_after got activity=%0d mem=%h ready=%b want 0 11223344 1",
                         late_rsp, mem[0][4], req_ready[0]);
    end
    $display("txn reset during RMW_WR, mem=%h", mem[0][4]);
  endtask

  task automatic test_back_to_back;
    int acc0 = -1, acc1 = -1, rsp0 = -1, rsp1 = -1, wr = -1;
    int ready_hi_between = 0;
    logic [31:0] rd0 = 32'hx, wd = 32'hx, wa = 32'hx;
    bit accepted;
    preload(1, 4'd2, 32'hCAFEF00D);
    preload(1, 4'd8, 32'h0);
    @(negedge clk);
    req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h8; req_wdata[1] = 32'h0;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (rsp_valid[1]) begin
        if (rsp0 < 0) begin rsp0 = c; rd0 = rsp_rdata[1]; end
        else if (rsp1 < 0) rsp1 = c;
      end
      if (mem_r_w[1] && wr < 0) begin wr = c; wd = mem_data[1]; wa = mem_addr[1]; end
      if (c >= 1 && c <= 5 && req_ready[1]) ready_hi_between++;
      accepted = req_valid[1] && req_ready[1];
      @(posedge clk); #1;
      if (accepted) begin
        if (acc0 < 0) begin
          acc0 = c;
          req_we[1] = 1'b1; req_funct3[1] = 3'b010; req_addr[1] = 32'h20; req_wdata[1] = 32'h55AA1234;
        end else begin
          acc1 = c;
          req_valid[1] = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    $display("txn b2b LW acc=%0d rsp=%0d rdata=%08h, SW acc=%0d wr=%0d rsp=%0d", acc0, rsp0, rd0, acc1, wr, rsp1);
    checks++;
    if (acc0 !== 0 || rsp0 !== 5 || rd0 !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_load got acc=%0d rsp=%0d rdata=%h want 0 5 cafef00d", acc0, rsp0, rd0);
    end
    checks++;
    if (ready_hi_between !== 0 || acc1 !== 6) begin
      errors++; $display("FAIL b2b_accept got ready_hi=%0d acc1=%0d want 0 6", ready_hi_between, acc1);
    end
    checks++;
    if (wr !== 7 || wd !== 32'h55AA1234 || wa !== 32'h20 || rsp1 !== 8) begin
      errors++; $display("FAIL b2b_store got wr=%0d data=%h addr=%h rsp=%0d want 7 55aa1234 00000020 8", wr, wd, wa, rsp1);
    end
    checks++;
    if (mem[1][8] !== 32'h55AA1234 || mem[1][2] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_mem got w8=%h w2=%h want 55aa1234 cafef00d", mem[1][8], mem[1][2]);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_loads();
    test_rmw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
